// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared types and sizing helpers for the completion stage:
//               FU result lanes, CDB broadcast packets.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    // Default sizing (FU lanes ordered ALU, MULT, LD, STORE, BR)
    localparam int c_num_fus    = 5;
    localparam int c_num_cdb    = 2;
    localparam int c_data_w     = 32;
    localparam int c_preg_idx_w = 6;

    typedef logic [c_data_w-1:0]     DATA;
    typedef logic [c_preg_idx_w-1:0] PHYS_REG_IDX;

    // Result presented by one functional unit
    typedef struct packed {
        PHYS_REG_IDX tag;
        DATA         data;
    } FU_RESULT;

    // One common-data-bus lane; also a physical regfile write port
    typedef struct packed {
        logic        valid;
        PHYS_REG_IDX tag;
        DATA         data;
    } CDB_PACKET;

    // Index width that never collapses to zero bits for a single-entry range
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_multi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_multi_arbiter
// Description : Combinational round-robin arbiter issuing up to N_GNT grants
//               per cycle. Requests are scanned starting at ptr; grant k goes
//               to the k-th requester found in scan order.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_multi_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int N_GNT = 2
) (
    input  logic [N_REQ-1:0]                 req,
    input  logic [idx_width(N_REQ)-1:0]      ptr,
    output logic [N_REQ-1:0]                 gnt,
    output logic [N_GNT-1:0]                 gnt_valid,
    output logic [idx_width(N_REQ)-1:0]      gnt_idx [N_GNT],
    output logic [idx_width(N_REQ)-1:0]      next_ptr
);

    localparam int c_idx_w = idx_width(N_REQ);
    localparam int c_cnt_w = idx_width(N_GNT + 1);

    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w-1:0] w_lane;
    logic [c_cnt_w-1:0] w_count;

    // Walk lanes ptr, ptr+1, ... (mod N_REQ) handing out grants in scan order
    always_comb begin
        gnt       = '0;
        gnt_valid = '0;
        for (int k = 0; k < N_GNT; k++) begin
            gnt_idx[k] = '0;
        end
        next_ptr = ptr;
        w_count  = '0;
        w_sum    = '0;
        w_lane   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_sum = {1'b0, ptr} + (c_idx_w+1)'(j);
            if (w_sum >= (c_idx_w+1)'(N_REQ)) begin
                w_sum = w_sum - (c_idx_w+1)'(N_REQ);
            end
            w_lane = w_sum[c_idx_w-1:0];
            if (req[w_lane] && (w_count < c_cnt_w'(N_GNT))) begin
                gnt[w_lane] = 1'b1;
                for (int k = 0; k < N_GNT; k++) begin
                    if (w_count == c_cnt_w'(k)) begin
                        gnt_valid[k] = 1'b1;
                        gnt_idx[k]   = w_lane;
                    end
                end
                // Pointer moves just past the last lane granted this cycle
                next_ptr = (w_lane == c_idx_w'(N_REQ - 1)) ? '0 : (w_lane + 1'b1);
                w_count  = w_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Completion stage. Holds one result per FU lane, round-robin
//               arbitrates held results onto NUM_CDB registered CDB lanes and
//               returns a per-lane stall to the issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU  = c_num_fus,
    parameter int NUM_CDB = c_num_cdb
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic [NUM_FU-1:0] fu_done,
    input  FU_RESULT          fu_result [NUM_FU],
    output logic [NUM_FU-1:0] stall_sig,
    output CDB_PACKET         cdb [NUM_CDB]
);

    localparam int c_idx_w = idx_width(NUM_FU);

    logic [NUM_FU-1:0]  r_buf_valid;
    FU_RESULT           r_buf [NUM_FU];
    logic [c_idx_w-1:0] r_rr_ptr;
    CDB_PACKET          r_cdb [NUM_CDB];

    logic [NUM_FU-1:0]  w_gnt;
    logic [NUM_CDB-1:0] w_gnt_valid;
    logic [c_idx_w-1:0] w_gnt_idx [NUM_CDB];
    logic [c_idx_w-1:0] w_next_ptr;
    logic [NUM_FU-1:0]  w_capture;

    rr_multi_arbiter #(
        .N_REQ (NUM_FU),
        .N_GNT (NUM_CDB)
    ) u_arb (
        .req       (r_buf_valid),
        .ptr       (r_rr_ptr),
        .gnt       (w_gnt),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx),
        .next_ptr  (w_next_ptr)
    );

    // A lane loads when its buffer is free or draining this cycle; tag 0 is a no-op result
    always_comb begin
        w_capture = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_capture[i] = fu_done[i] && (fu_result[i].tag != '0)
                           && (!r_buf_valid[i] || w_gnt[i]);
        end
    end

    // Stall is purely from held state, so there is no loop through fu_done
    assign stall_sig = r_buf_valid & ~w_gnt;

    // Holding buffers: refill wins over release when both happen on one edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_buf[i] <= '0;
            end
        end else if (squash) begin
            r_buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_capture[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf[i]       <= fu_result[i];
                end else if (w_gnt[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // CDB registers: lane k carries grant k, unused lanes broadcast all-zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                r_cdb[k] <= '0;
            end
        end else if (squash) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                r_cdb[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (w_gnt_valid[k]) begin
                    r_cdb[k] <= {1'b1, r_buf[w_gnt_idx[k]]};
                end else begin
                    r_cdb[k] <= '0;
                end
            end
        end
    end

    // Round-robin pointer advances past the last granted lane
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (squash) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    assign cdb = r_cdb;

endmodule
`default_nettype wire
